panel_sequencer: RTL and testbench
==================================

Name: panel_sequencer

Overview:
- Front-panel run/halt/step controller for the physical 6502.
- Converts one-cycle keyboard strobes into sequenced control of the CPU:
  - the reset pulse on phys6502_RESn;
  - minimum-width NMI pulses, used to enter the FPGA monitor at 0xFF00-0xFFFF;
  - a resume strobe to cpu_control.
- Replaces the ad-hoc nmiCounter logic and drives led_run/led_halt for display.
- Sits between keyboard, cpu_control and the CPU pins, all in the CLK25MHZ domain.

Parameters:
- RES_CYCLES, 256, CLK25MHZ cycles phys6502_RESn is held low (≥10 µs, ≥2 PHI0 periods).
- NMI_CYCLES, 128, CLK25MHZ cycles NMIn is held low per halt request.
- HALT_TIMEOUT, 65535, CLK25MHZ cycles to wait for halt_ack before flagging an error.

Ports:
- CLK25MHZ  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- b_reset  in  1  one-cycle keyboard strobe.
- b_runhalt  in  1  one-cycle keyboard strobe.
- b_step  in  1  one-cycle keyboard strobe.
- b_irq  in  1  one-cycle keyboard strobe.
- phi2_rise  in  1  one-cycle pulse on a synchronized PHI2 rising edge.
- sync_s  in  1  synchronized SYNC (opcode fetch).
- halt_ack  in  1  one-cycle pulse from cpu_control: the CPU has parked in the monitor loop.
- resume_ack  in  1  one-cycle pulse from cpu_control: the CPU has executed RTI back to user code.
- resume  out  1  one-cycle strobe to cpu_control requesting exit from the monitor.
- NMIn  out  1  to the CPU NMI pin, active low.
- phys6502_RESn  out  1  to the CPU reset pin, active low.
- IRQ  out  1  IRQ pin drive.
- led_run  out  1  CPU running user code.
- led_halt  out  1  CPU parked in the monitor.
- halt_err  out  1  sticky: a halt request timed out.

Behaviour:
- States: RESET_HOLD, RUN, HALT_REQ, HALTED, RESUMING, STEP_ARM, STEP_NMI.
- Reset values (rst_n low): state=RESET_HOLD, counter cleared, phys6502_RESn=0, NMIn=1, resume=0, IRQ=0, led_run=0, led_halt=0, halt_err=0.
- One shared 16-bit counter. It is cleared on every state entry and increments each CLK25MHZ cycle while the state uses it.
- RESET_HOLD:
  - phys6502_RESn=0.
  - After RES_CYCLES cycles, go to RUN with phys6502_RESn=1 on the same edge.
- RUN:
  - led_run=1.
  - b_runhalt → HALT_REQ.
  - b_step is ignored.
- HALT_REQ:
  - NMIn=0 for the first NMI_CYCLES cycles, then 1.
  - halt_ack → HALTED.
  - Counter reaching HALT_TIMEOUT → set halt_err, return to RUN.
  - halt_ack arriving while NMIn is still low: NMIn still goes high immediately; the pulse is truncated.
- HALTED:
  - led_halt=1.
  - b_runhalt → pulse resume for one cycle → RESUMING.
  - b_step → pulse resume for one cycle → STEP_ARM.
- RESUMING: on resume_ack → RUN.
- STEP_ARM:
  - Wait for resume_ack, then for the first cycle with phi2_rise & sync_s (fetch of the user opcode) → STEP_NMI.
  - The NMI is asserted during that instruction, so the CPU completes exactly one instruction before vectoring.
- STEP_NMI:
  - Identical to HALT_REQ, including NMI pulse and timeout; halt_ack → HALTED.
  - On timeout, set halt_err and go to RUN.
- led_run and led_halt are never both 1. Both are 0 in RESET_HOLD, HALT_REQ, RESUMING, STEP_ARM and STEP_NMI.
- Strobe priority when several are asserted in the same cycle: b_reset > b_runhalt > b_step. Lower-priority strobes in that cycle are dropped, not queued.
- b_reset from any state, including mid-NMI pulse: → RESET_HOLD next cycle, NMIn=1, counter restarted, halt_err cleared.
- Strobes not listed for the current state are ignored.
- The counter saturates and does not wrap.
- Without PANEL_IRQ_EN, IRQ is tied 0 and b_irq is ignored.

Optional Feature:
- Macro: PANEL_IRQ_EN.
- When defined: in RUN, b_irq drives IRQ=1 for NMI_CYCLES cycles. The pulse aborts, with IRQ=0, on leaving RUN. b_irq during an active pulse restarts it.
- When undefined: IRQ is constant 0, b_irq is unused, and no IRQ counter is instantiated.

Decomposition:
- Package panel_pkg holds:
  - the state enum, 3-bit encoding, RESET_HOLD=0;
  - default localparams RES_CYCLES_DEF, NMI_CYCLES_DEF, HALT_TIMEOUT_DEF.
- One natural sub-module, pulse_stretch: loadable down-counter producing a fixed-width active-low pulse with abort input. It is used for NMIn, and for IRQ when PANEL_IRQ_EN is defined.

Test Plan:
- Power-on: release rst_n → phys6502_RESn=0 for exactly 256 cycles, then 1; led_run=1 next cycle.
- Halt: in RUN, b_runhalt → NMIn low exactly 128 cycles; halt_ack at cycle 300 → led_halt=1, led_run=0.
- Step: in HALTED, b_step → resume high 1 cycle; resume_ack, then phi2_rise with sync_s=1 → NMIn falls next cycle; halt_ack → HALTED again.
- Timeout: in HALT_REQ, no halt_ack for 65535 cycles → halt_err=1, state RUN. A following b_reset clears halt_err.
- Priority/abort: b_reset and b_runhalt in the same cycle during an NMI pulse → NMIn=1 next cycle, phys6502_RESn=0, and no halt occurs.
- With PANEL_IRQ_EN: b_irq in RUN → IRQ high 128 cycles. b_runhalt at cycle 50 → IRQ=0 next cycle. Without the macro, IRQ stays 0.

Source files
------------

// File: rtl/panel_pkg.sv
// panel_pkg: shared types and defaults for the front-panel run/halt/step
// sequencer.
//   panel_state_e    - sequencer states, 3-bit, RESET_HOLD encoded as 0
//   *_DEF            - default cycle counts (CLK25MHZ cycles)
//   CNT_W            - width of the shared state counter and pulse counters
//   sat_inc()        - saturating increment, so long waits never wrap
package panel_pkg;

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    RUN        = 3'd1,
    HALT_REQ   = 3'd2,
    HALTED     = 3'd3,
    RESUMING   = 3'd4,
    STEP_ARM   = 3'd5,
    STEP_NMI   = 3'd6
  } panel_state_e;

  localparam int unsigned RES_CYCLES_DEF   = 256;
  localparam int unsigned NMI_CYCLES_DEF   = 128;
  localparam int unsigned HALT_TIMEOUT_DEF = 65535;

  localparam int CNT_W = 16;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pulse_stretch.sv
// pulse_stretch: loadable down-counter producing a fixed-width active-low
// pulse. A load starts (or restarts) a WIDTH-cycle low pulse beginning the
// cycle after the load; abort ends it on the next edge. Abort wins over load
// so that a pulse requested in the same cycle the owner gives up is dropped.
// Ports:
//   CLK25MHZ  - system clock
//   rst_n     - asynchronous active-low reset (output idles high)
//   load_i    - start/restart the pulse
//   abort_i   - terminate the pulse
//   pulse_n_o - active-low pulse output (registered)
module pulse_stretch
  import panel_pkg::*;
#(
  parameter int unsigned WIDTH = NMI_CYCLES_DEF
) (
  input  logic CLK25MHZ,
  input  logic rst_n,
  input  logic load_i,
  input  logic abort_i,
  output logic pulse_n_o
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WIDTH);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (abort_i) begin
      cnt_d    = '0;
      active_d = 1'b0;
    end else if (load_i) begin
      cnt_d    = LOAD_VAL;
      active_d = (LOAD_VAL != '0);
    end else if (cnt_q != '0) begin
      // active stays set while the count is still at least one after this edge
      cnt_d    = cnt_q - 1'b1;
      active_d = (cnt_q != CNT_W'(1));
    end
  end

  always_ff @(posedge CLK25MHZ or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign pulse_n_o = ~active_q;

endmodule

// File: rtl/panel_sequencer.sv
// panel_sequencer: front-panel run/halt/step controller for the physical 6502.
// Turns one-cycle keyboard strobes into a CPU reset pulse, minimum-width NMI
// pulses (entry to the FPGA monitor) and a resume strobe to cpu_control.
// Build option: define PANEL_IRQ_EN to let b_irq raise a timed IRQ pulse while
// running; otherwise IRQ is tied low and b_irq is unused.
// Ports:
//   CLK25MHZ, rst_n          - clock, asynchronous active-low reset
//   b_reset/b_runhalt/b_step - keyboard strobes (priority in that order)
//   b_irq                    - keyboard strobe, IRQ request (optional)
//   phi2_rise, sync_s        - synchronized PHI2 rising edge and SYNC
//   halt_ack, resume_ack     - handshakes from cpu_control
//   resume                   - one-cycle request to leave the monitor
//   NMIn, phys6502_RESn, IRQ - CPU pin drives
//   led_run, led_halt        - status display
//   halt_err                 - sticky halt timeout flag, cleared by b_reset
module panel_sequencer
  import panel_pkg::*;
#(
  parameter int unsigned RES_CYCLES   = RES_CYCLES_DEF,
  parameter int unsigned NMI_CYCLES   = NMI_CYCLES_DEF,
  parameter int unsigned HALT_TIMEOUT = HALT_TIMEOUT_DEF
) (
  input  logic CLK25MHZ,
  input  logic rst_n,
  input  logic b_reset,
  input  logic b_runhalt,
  input  logic b_step,
  input  logic b_irq,
  input  logic phi2_rise,
  input  logic sync_s,
  input  logic halt_ack,
  input  logic resume_ack,
  output logic resume,
  output logic NMIn,
  output logic phys6502_RESn,
  output logic IRQ,
  output logic led_run,
  output logic led_halt,
  output logic halt_err
);

  // The counter holds the number of cycles already spent in the state, so a
  // state that must last N cycles leaves when the count shows N-1.
  localparam logic [CNT_W-1:0] RES_LAST = CNT_W'(RES_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(HALT_TIMEOUT - 1);

  panel_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halt_err_q, halt_err_d;
  logic             resume_q, resume_d;
  logic             ack_seen_q, ack_seen_d;
  logic             nmi_load, nmi_abort;
  logic             cnt_used;

  always_comb begin
    state_d    = state_q;
    halt_err_d = halt_err_q;
    resume_d   = 1'b0;
    ack_seen_d = ack_seen_q;

    if (b_reset) begin
      state_d    = RESET_HOLD;
      halt_err_d = 1'b0;
    end else begin
      case (state_q)
        RESET_HOLD: if (cnt_q == RES_LAST) state_d = RUN;
        RUN:        if (b_runhalt) state_d = HALT_REQ;
        HALT_REQ, STEP_NMI: begin
          if (halt_ack) begin
            state_d = HALTED;
          end else if (cnt_q == TMO_LAST) begin
            state_d    = RUN;
            halt_err_d = 1'b1;
          end
        end
        HALTED: begin
          if (b_runhalt) begin
            state_d  = RESUMING;
            resume_d = 1'b1;
          end else if (b_step) begin
            state_d  = STEP_ARM;
            resume_d = 1'b1;
          end
        end
        RESUMING: if (resume_ack) state_d = RUN;
        STEP_ARM: begin
          // The fetch that arms the NMI must come strictly after resume_ack,
          // i.e. it is the first opcode fetched back in user code.
          if (!ack_seen_q) ack_seen_d = resume_ack;
          else if (phi2_rise && sync_s) state_d = STEP_NMI;
        end
        default: state_d = RESET_HOLD;
      endcase
    end

    if (state_d != STEP_ARM) ack_seen_d = 1'b0;

    cnt_used = (state_q == RESET_HOLD) || (state_q == HALT_REQ) ||
               (state_q == STEP_NMI);

    // b_reset restarts the count even when already in RESET_HOLD
    if (b_reset || (state_d != state_q)) cnt_d = '0;
    else if (cnt_used)                   cnt_d = sat_inc(cnt_q);
    else                                 cnt_d = cnt_q;

    nmi_load  = ((state_d == HALT_REQ) || (state_d == STEP_NMI)) &&
                (state_d != state_q);
    nmi_abort = ((state_q == HALT_REQ) || (state_q == STEP_NMI)) &&
                (state_d != state_q);
  end

  always_ff @(posedge CLK25MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_HOLD;
      cnt_q      <= '0;
      halt_err_q <= 1'b0;
      resume_q   <= 1'b0;
      ack_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      halt_err_q <= halt_err_d;
      resume_q   <= resume_d;
      ack_seen_q <= ack_seen_d;
    end
  end

  pulse_stretch #(.WIDTH(NMI_CYCLES)) u_nmi (
    .CLK25MHZ (CLK25MHZ),
    .rst_n    (rst_n),
    .load_i   (nmi_load),
    .abort_i  (nmi_abort),
    .pulse_n_o(NMIn)
  );

`ifdef PANEL_IRQ_EN
  logic irq_n;
  logic irq_load, irq_abort;

  // Only accept the request if we are staying in RUN; leaving RUN kills it.
  assign irq_load  = (state_q == RUN) && (state_d == RUN) && b_irq;
  assign irq_abort = (state_q == RUN) && (state_d != RUN);

  pulse_stretch #(.WIDTH(NMI_CYCLES)) u_irq (
    .CLK25MHZ (CLK25MHZ),
    .rst_n    (rst_n),
    .load_i   (irq_load),
    .abort_i  (irq_abort),
    .pulse_n_o(irq_n)
  );

  assign IRQ = ~irq_n;
`else
  logic unused_b_irq;
  assign unused_b_irq = b_irq;
  assign IRQ          = 1'b0;
`endif

  assign phys6502_RESn = (state_q != RESET_HOLD);
  assign led_run       = (state_q == RUN);
  assign led_halt      = (state_q == HALTED);
  assign resume        = resume_q;
  assign halt_err      = halt_err_q;

endmodule

// File: tb/tb_panel_sequencer.sv
module tb_panel_sequencer;

  localparam int RES_LEN = 256;
  localparam int NMI_LEN = 128;
  localparam int TMO_LEN = 65535;

  logic CLK25MHZ = 1'b0;
  logic rst_n = 1'b0;
  logic b_reset = 1'b0, b_runhalt = 1'b0, b_step = 1'b0, b_irq = 1'b0;
  logic phi2_rise = 1'b0, sync_s = 1'b0, halt_ack = 1'b0, resume_ack = 1'b0;
  logic resume, NMIn, phys6502_RESn, IRQ, led_run, led_halt, halt_err;

  int vectors = 0;
  int miscompares = 0;

  always #20 CLK25MHZ = ~CLK25MHZ;

  panel_sequencer dut (
    .CLK25MHZ(CLK25MHZ), .rst_n(rst_n),
    .b_reset(b_reset), .b_runhalt(b_runhalt), .b_step(b_step), .b_irq(b_irq),
    .phi2_rise(phi2_rise), .sync_s(sync_s),
    .halt_ack(halt_ack), .resume_ack(resume_ack),
    .resume(resume), .NMIn(NMIn), .phys6502_RESn(phys6502_RESn), .IRQ(IRQ),
    .led_run(led_run), .led_halt(led_halt), .halt_err(halt_err)
  );

  // Reference rule: an NMI pulse lasts NMI_LEN cycles unless the ack ends the
  // request earlier, in which case it is cut at the ack.
  function automatic int exp_nmi_low(input int ack_cycle);
    return (ack_cycle < NMI_LEN) ? ack_cycle : NMI_LEN;
  endfunction

  function automatic logic rnd();
    return ($urandom_range(7) == 0);
  endfunction

  // Each tick samples right after an active edge; inputs set before a tick
  // are seen by that edge.
  task automatic tick();
    @(posedge CLK25MHZ);
    #1;
  endtask

  task automatic clear_inputs();
    b_reset = 0; b_runhalt = 0; b_step = 0; b_irq = 0;
    phi2_rise = 0; sync_s = 0; halt_ack = 0; resume_ack = 0;
  endtask

  // Spends k cycles in a halt request with ignored-strobe noise, acking on
  // the k-th; reports how many of those cycles had NMIn low.
  task automatic nmi_window(input int k, output int lows, output bit leds_bad);
    lows = 0;
    leds_bad = 0;
    for (int c = 1; c <= k; c++) begin
      if (NMIn === 1'b0) lows++;
      if (led_run !== 1'b0 || led_halt !== 1'b0) leds_bad = 1;
      b_step = rnd(); b_runhalt = rnd(); resume_ack = rnd();
      halt_ack = (c == k);
      tick();
      clear_inputs();
    end
  endtask

  task automatic go_run();
    int n;
    b_reset = 1; tick(); b_reset = 0;
    n = 0;
    while (led_run !== 1'b1 && n < 400) begin n++; tick(); end
    vectors++;
    if (led_run !== 1'b1) begin
      miscompares++;
      $display("FAIL go_run: led_run=%b after %0d cycles, required 1", led_run, n);
    end
  endtask

  task automatic test_reset();
    int lows;
    bit nmi_bad;
    clear_inputs();
    rst_n = 0;
    repeat (3) tick();
    vectors++;
    if ({phys6502_RESn, NMIn, resume, IRQ, led_run, led_halt, halt_err} !== 7'b0100000) begin
      miscompares++;
      $display("FAIL reset_values: {RESn,NMIn,resume,IRQ,run,halt,err}=%b required 0100000",
               {phys6502_RESn, NMIn, resume, IRQ, led_run, led_halt, halt_err});
    end
    rst_n = 1;
    lows = 0;
    nmi_bad = 0;
    while (phys6502_RESn === 1'b0 && lows < 400) begin
      lows++;
      if (NMIn !== 1'b1) nmi_bad = 1;
      b_runhalt = rnd(); b_step = rnd(); halt_ack = rnd();
      tick();
      clear_inputs();
    end
    vectors++;
    if (lows != RES_LEN) begin
      miscompares++;
      $display("FAIL poweron_res_width: RESn low %0d cycles, required %0d", lows, RES_LEN);
    end
    vectors++;
    if (led_run !== 1'b1 || led_halt !== 1'b0 || nmi_bad) begin
      miscompares++;
      $display("FAIL poweron_run: led_run=%b led_halt=%b nmi_glitch=%0b, required 1 0 0",
               led_run, led_halt, nmi_bad);
    end
    $display("reset: RESn low %0d cycles", lows);
  endtask

  task automatic test_halt(input int k);
    int lows;
    bit leds_bad;
    b_runhalt = 1; b_step = rnd(); tick(); clear_inputs();
    nmi_window(k, lows, leds_bad);
    vectors++;
    if (lows != exp_nmi_low(k) || leds_bad) begin
      miscompares++;
      $display("FAIL halt_nmi_width(ack=%0d): NMIn low %0d leds_bad=%0b, required %0d 0",
               k, lows, leds_bad, exp_nmi_low(k));
    end
    vectors++;
    if (led_halt !== 1'b1 || led_run !== 1'b0 || NMIn !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_reached(ack=%0d): halt=%b run=%b NMIn=%b, required 1 0 1",
               k, led_halt, led_run, NMIn);
    end
    $display("halt: ack at %0d, NMIn low %0d", k, lows);
  endtask

  task automatic test_resume();
    int d;
    bit bad;
    repeat ($urandom_range(1, 5)) begin
      halt_ack = rnd(); resume_ack = rnd(); phi2_rise = rnd(); sync_s = rnd();
      tick(); clear_inputs();
    end
    b_runhalt = 1; tick(); clear_inputs();
    vectors++;
    if (resume !== 1'b1 || led_run !== 1'b0 || led_halt !== 1'b0) begin
      miscompares++;
      $display("FAIL resume_strobe: resume=%b run=%b halt=%b, required 1 0 0",
               resume, led_run, led_halt);
    end
    tick();
    bad = (resume !== 1'b0);
    d = $urandom_range(1, 20);
    for (int i = 0; i < d; i++) begin
      if (led_run !== 1'b0 || resume !== 1'b0) bad = 1;
      b_runhalt = rnd(); b_step = rnd(); halt_ack = rnd();
      tick(); clear_inputs();
    end
    resume_ack = 1; tick(); clear_inputs();
    vectors++;
    if (bad || led_run !== 1'b1) begin
      miscompares++;
      $display("FAIL resume_to_run: early/extra=%0b led_run=%b, required 0 1", bad, led_run);
    end
    $display("resume: ack after %0d cycles", d);
  endtask

  task automatic test_step(input int k);
    int lows;
    bit leds_bad, early;
    b_step = 1; tick(); clear_inputs();
    vectors++;
    if (resume !== 1'b1 || led_halt !== 1'b0 || led_run !== 1'b0) begin
      miscompares++;
      $display("FAIL step_resume: resume=%b halt=%b run=%b, required 1 0 0",
               resume, led_halt, led_run);
    end
    tick();
    early = (resume !== 1'b0);
    // fetches before resume_ack must not arm the NMI
    repeat ($urandom_range(1, 10)) begin
      if (NMIn !== 1'b1) early = 1;
      phi2_rise = rnd() | rnd(); sync_s = $urandom_range(1);
      b_step = rnd(); b_runhalt = rnd();
      tick(); clear_inputs();
    end
    resume_ack = 1; tick(); clear_inputs();
    repeat ($urandom_range(1, 12)) begin
      if (NMIn !== 1'b1 || led_run !== 1'b0) early = 1;
      phi2_rise = $urandom_range(1);
      sync_s = phi2_rise ? 1'b0 : logic'($urandom_range(1));
      tick(); clear_inputs();
    end
    if (NMIn !== 1'b1) early = 1;
    phi2_rise = 1; sync_s = 1; tick(); clear_inputs();
    vectors++;
    if (early || NMIn !== 1'b0) begin
      miscompares++;
      $display("FAIL step_nmi_fall: premature=%0b NMIn=%b, required 0 0", early, NMIn);
    end
    nmi_window(k, lows, leds_bad);
    vectors++;
    if (lows != exp_nmi_low(k) || leds_bad || led_halt !== 1'b1) begin
      miscompares++;
      $display("FAIL step_halt(ack=%0d): NMIn low %0d leds_bad=%0b halt=%b, required %0d 0 1",
               k, lows, leds_bad, led_halt, exp_nmi_low(k));
    end
    $display("step: ack at %0d, NMIn low %0d", k, lows);
  endtask

  task automatic test_irq();
    int highs;
    bit bad;
`ifdef PANEL_IRQ_EN
    int lows;
    bit leds_bad;
    b_irq = 1; tick(); clear_inputs();
    highs = 0;
    while (IRQ === 1'b1 && highs < 300) begin
      highs++; b_step = rnd(); tick(); clear_inputs();
    end
    vectors++;
    if (highs != NMI_LEN) begin
      miscompares++;
      $display("FAIL irq_width: IRQ high %0d, required %0d", highs, NMI_LEN);
    end
    b_irq = 1; tick(); clear_inputs();
    repeat (59) tick();
    b_irq = 1; tick(); clear_inputs();
    highs = 0;
    while (IRQ === 1'b1 && highs < 300) begin highs++; tick(); end
    vectors++;
    if (highs != NMI_LEN) begin
      miscompares++;
      $display("FAIL irq_restart: IRQ high %0d after restart, required %0d", highs, NMI_LEN);
    end
    b_irq = 1; tick(); clear_inputs();
    repeat (49) tick();
    bad = (IRQ !== 1'b1);
    b_runhalt = 1; tick(); clear_inputs();
    vectors++;
    if (bad || IRQ !== 1'b0 || led_run !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_abort: dropped_early=%0b IRQ=%b run=%b, required 0 0 0", bad, IRQ, led_run);
    end
    nmi_window(50, lows, leds_bad);
    b_irq = 1; tick(); clear_inputs();
    repeat (3) tick();
    vectors++;
    if (IRQ !== 1'b0 || led_halt !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_halted_ignored: IRQ=%b halt=%b, required 0 1", IRQ, led_halt);
    end
    go_run();
    $display("irq: pulse, restart and abort exercised");
`else
    bad = 0;
    highs = 0;
    b_irq = 1; tick(); clear_inputs();
    for (int i = 0; i < 200; i++) begin
      if (IRQ !== 1'b0) begin bad = 1; highs++; end
      b_irq = rnd(); tick(); clear_inputs();
    end
    vectors++;
    if (bad || led_run !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_disabled: IRQ high %0d cycles run=%b, required 0 1", highs, led_run);
    end
    $display("irq: disabled build, IRQ held low");
`endif
  endtask

  task automatic test_priority();
    int m, lows;
    bit halt_seen, leds_bad;
    b_runhalt = 1; tick(); clear_inputs();
    m = $urandom_range(1, 100);
    repeat (m - 1) tick();
    vectors++;
    if (NMIn !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_mid_pulse: NMIn=%b at cycle %0d, required 0", NMIn, m);
    end
    b_reset = 1; b_runhalt = 1; tick(); clear_inputs();
    vectors++;
    if ({NMIn, phys6502_RESn, led_halt, led_run} !== 4'b1000) begin
      miscompares++;
      $display("FAIL prio_reset_abort: {NMIn,RESn,halt,run}=%b required 1000",
               {NMIn, phys6502_RESn, led_halt, led_run});
    end
    halt_seen = 0;
    lows = 0;
    for (int c = 0; c < 100; c++) begin
      if (phys6502_RESn === 1'b0) lows++;
      if (led_halt !== 1'b0) halt_seen = 1;
      halt_ack = rnd(); tick(); clear_inputs();
    end
    b_reset = 1; tick(); clear_inputs();
    lows = 0;
    while (phys6502_RESn === 1'b0 && lows < 400) begin
      lows++;
      if (led_halt !== 1'b0) halt_seen = 1;
      halt_ack = rnd(); tick(); clear_inputs();
    end
    vectors++;
    if (lows != RES_LEN || halt_seen || led_run !== 1'b1) begin
      miscompares++;
      $display("FAIL prio_reset_restart: RESn low %0d halt_seen=%0b run=%b, required %0d 0 1",
               lows, halt_seen, led_run, RES_LEN);
    end
    b_runhalt = 1; tick(); clear_inputs();
    nmi_window(200, lows, leds_bad);
    b_runhalt = 1; b_step = 1; tick(); clear_inputs();
    vectors++;
    if (resume !== 1'b1) begin
      miscompares++;
      $display("FAIL prio_halted_resume: resume=%b, required 1", resume);
    end
    tick();
    resume_ack = 1; tick(); clear_inputs();
    vectors++;
    if (led_run !== 1'b1) begin
      miscompares++;
      $display("FAIL prio_runhalt_over_step: led_run=%b, required 1", led_run);
    end
    $display("priority: reset at NMI cycle %0d", m);
  endtask

  task automatic test_timeout();
    int c, lows;
    bit err_early;
    b_runhalt = 1; tick(); clear_inputs();
    c = 0;
    lows = 0;
    err_early = 0;
    while (led_run !== 1'b1 && c < 70000) begin
      c++;
      if (NMIn === 1'b0) lows++;
      if (halt_err !== 1'b0) err_early = 1;
      b_step = rnd(); b_runhalt = rnd(); resume_ack = rnd();
      tick(); clear_inputs();
    end
    vectors++;
    if (c != TMO_LEN || lows != NMI_LEN || err_early) begin
      miscompares++;
      $display("FAIL timeout_len: HALT_REQ %0d cycles NMIn low %0d err_early=%0b, required %0d %0d 0",
               c, lows, err_early, TMO_LEN, NMI_LEN);
    end
    vectors++;
    if (halt_err !== 1'b1 || led_run !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_flag: halt_err=%b run=%b, required 1 1", halt_err, led_run);
    end
    b_reset = 1; tick(); clear_inputs();
    vectors++;
    if (halt_err !== 1'b0 || phys6502_RESn !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_clear: halt_err=%b RESn=%b, required 0 0", halt_err, phys6502_RESn);
    end
    repeat (RES_LEN + 2) tick();
    vectors++;
    if (halt_err !== 1'b0 || led_run !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_after_reset: halt_err=%b run=%b, required 0 1", halt_err, led_run);
    end
    $display("timeout: HALT_REQ lasted %0d cycles", c);
  endtask

  initial begin
    test_reset();
    test_halt(300);
    test_resume();
    test_halt($urandom_range(1, 127));
    test_step($urandom_range(1, 400));
    test_resume();
    test_halt($urandom_range(129, 600));
    test_resume();
    test_irq();
    test_priority();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
